// File: rtl/wb_daq_multichannel_dma.sv
// wb_daq_multichannel_dma: round-robin multi-channel DAQ to Wishbone write DMA.
// Each enabled channel streams words into its own ring buffer located at
// base_addr[k] + offset[k]*(dw/8). One Wishbone classic write is issued at a time.
// Optional feature macro: WB_DAQ_DMA_TIMEOUT_EN (1024-cycle write timeout abort).
module wb_daq_multichannel_dma #(
  parameter int NUM_CHANNELS = 4,
  parameter int dw           = 32,
  parameter int aw           = 32,
  parameter int BUF_WORDS    = 256
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst_n,
  input  logic [NUM_CHANNELS-1:0]    enable,
  input  logic [NUM_CHANNELS*aw-1:0] base_addr,
  input  logic [NUM_CHANNELS*dw-1:0] ch_data,
  input  logic [NUM_CHANNELS-1:0]    ch_valid,
  output logic [NUM_CHANNELS-1:0]    ch_ready,
  output logic [aw-1:0]              wb_adr_o,
  output logic [dw-1:0]              wb_dat_o,
  output logic [dw/8-1:0]            wb_sel_o,
  output logic                       wb_we_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic [2:0]                 wb_cti_o,
  output logic [1:0]                 wb_bte_o,
  input  logic [dw-1:0]              wb_dat_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  input  logic                       wb_rty_i,
  output logic [NUM_CHANNELS-1:0]    wrap_irq,
  output logic [NUM_CHANNELS-1:0]    err_flag
);

  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int OW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam logic [OW-1:0] OFF_LAST       = OW'(BUF_WORDS - 1);
  localparam logic [aw-1:0] BYTES_PER_WORD = aw'(dw / 8);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_BACKOFF = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_bo_cnt;
  logic [CW-1:0]           r_grant;      // last granted channel; doubles as round-robin pointer
  logic [aw-1:0]           r_adr;
  logic [dw-1:0]           r_dat;
  logic [OW-1:0]           r_offset [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_err;
  logic [NUM_CHANNELS-1:0] r_en_d;

  logic [NUM_CHANNELS-1:0] w_req;
  logic [NUM_CHANNELS-1:0] w_en_rise;
  logic [NUM_CHANNELS-1:0] w_grant_oh;
  logic [OW-1:0]           w_off_eff [NUM_CHANNELS];
  logic [aw-1:0]           w_ch_adr  [NUM_CHANNELS];
  logic                    w_any;
  logic [CW-1:0]           w_pick;
  logic                    w_latch;
  logic                    w_ack_ok;
  logic                    w_err_hit;
  logic                    w_timeout;
  logic                    w_unused_dat;

  assign w_req        = ch_valid & enable;
  assign w_en_rise    = enable & ~r_en_d;
  assign w_grant_oh   = {{(NUM_CHANNELS-1){1'b0}}, 1'b1} << r_grant;
  assign w_unused_dat = ^wb_dat_i;

  // Per-channel write address; a channel enabled this very cycle starts from offset 0
  always_comb begin
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      w_off_eff[k] = w_en_rise[k] ? '0 : r_offset[k];
      w_ch_adr[k]  = base_addr[k*aw +: aw] + aw'(w_off_eff[k]) * BYTES_PER_WORD;
    end
  end

  // Round-robin pick: first requester after the last granted channel
  always_comb begin
    int unsigned c;
    c      = 0;
    w_any  = 1'b0;
    w_pick = r_grant;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      c = (32'(r_grant) + i) % NUM_CHANNELS;
      if (!w_any && w_req[CW'(c)]) begin
        w_any  = 1'b1;
        w_pick = CW'(c);
      end
    end
  end

`ifdef WB_DAQ_DMA_TIMEOUT_EN
  logic [9:0] r_to_cnt;

  // Cycles spent in the current write attempt; zero whenever not in WRITE
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)                r_to_cnt <= '0;
    else if (r_state == S_WRITE)  r_to_cnt <= r_to_cnt + 1'b1;
    else                          r_to_cnt <= '0;
  end

  assign w_timeout = (r_state == S_WRITE) && (r_to_cnt == '1);
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and termination decode; priority err > rty > ack > timeout
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ack_ok    = 1'b0;
    w_err_hit   = 1'b0;
    ch_ready    = '0;
    wrap_irq    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_latch     = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wb_err_i) begin
          w_err_hit   = 1'b1;
          ch_ready    = w_grant_oh;
          w_state_nxt = S_IDLE;
        end else if (wb_rty_i) begin
          w_state_nxt = S_BACKOFF;
        end else if (wb_ack_i) begin
          w_ack_ok    = 1'b1;
          ch_ready    = w_grant_oh;
          if (r_offset[r_grant] == OFF_LAST) wrap_irq = w_grant_oh;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_err_hit   = 1'b1;
          ch_ready    = w_grant_oh;
          w_state_nxt = S_IDLE;
        end
      end
      S_BACKOFF: begin
        if (r_bo_cnt) w_state_nxt = S_WRITE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus two-cycle backoff counter
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state  <= S_IDLE;
      r_bo_cnt <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bo_cnt <= (r_state == S_BACKOFF) ? ~r_bo_cnt : 1'b0;
    end
  end

  // Capture grant, address and data when a transfer starts; held through retries
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_grant <= CW'(NUM_CHANNELS - 1);
      r_adr   <= '0;
      r_dat   <= '0;
    end else if (w_latch) begin
      r_grant <= w_pick;
      r_adr   <= w_ch_adr[w_pick];
      r_dat   <= ch_data[w_pick*dw +: dw];
    end
  end

  // Per-channel offsets and sticky error flags; an enable rising edge restarts the channel
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) r_offset[k] <= '0;
      r_err  <= '0;
      r_en_d <= '0;
    end else begin
      r_en_d <= enable;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        if (w_en_rise[k]) begin
          r_offset[k] <= '0;
          r_err[k]    <= 1'b0;
        end else if (r_grant == CW'(k)) begin
          if (w_ack_ok)  r_offset[k] <= r_offset[k] + 1'b1;
          if (w_err_hit) r_err[k]    <= 1'b1;
        end
      end
    end
  end

  assign wb_cyc_o = (r_state == S_WRITE);
  assign wb_stb_o = (r_state == S_WRITE);
  assign wb_we_o  = (r_state == S_WRITE);
  assign wb_sel_o = {(dw/8){wb_cyc_o}};
  assign wb_cti_o = '0;
  assign wb_bte_o = '0;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign err_flag = r_err;

endmodule
